dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (slave) side of the CPU data-memory interface.
- Accepts one load/store request at a time from an initiator over a valid/ready handshake.
- Models a configurable-latency word-organised data RAM with byte-lane writes.
- Returns read data and an error flag over a second valid/ready handshake.
- Replaces the zero-latency data memory when the core is moved to a stalling, multi-cycle memory port.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; legal word indices 0..DEPTH-1.
- WAIT_CYCLES, 2, extra wait states between request acceptance and the access (0..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index = req_addr[31:2].
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; be[0] controls bits 7:0 (little-endian lanes).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts response.
- rsp_rdata  output  32  load data; 0 for stores and errored accesses.
- rsp_err  output  1  access faulted (out of range, or misaligned when the feature is enabled).

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- Reset does not clear the RAM array.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: latch write, addr, wdata, be; load counter=WAIT_CYCLES; go WAIT.
- WAIT:
  - req_ready=0.
  - If counter!=0: decrement.
  - If counter==0: perform the access at this edge and go RESP.
- Access rules:
  - Out of range (req_addr[31:2] >= DEPTH): rsp_err=1, rsp_rdata=0, no write.
  - Store: write only lanes with be=1. be=4'b0000 completes with err=0 and leaves memory unchanged. rsp_rdata=0.
  - Load: rsp_rdata = full word; be ignored.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until handshake.
  - On rsp_valid&&rsp_ready: go IDLE, rsp_valid=0, rsp_rdata and rsp_err cleared.
  - If rsp_ready stays low, hold indefinitely.
- Exactly one outstanding request. Requests presented outside IDLE are ignored (req_ready=0) and must be held by the initiator.
- rsp_ready already high on the rsp_valid rising edge: handshake completes on the next edge (one RESP cycle minimum). Next request is accepted no earlier than the edge after return to IDLE.
- Reset during WAIT: request aborted, no write committed.
- Reset during RESP: response dropped.
- req_* changes after acceptance have no effect on the latched request.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: alignment is checked against req_be and req_addr[1:0].
  - Store with be=4'b1111 and addr[1:0]!=0 faults.
  - Store with be in {0011,1100} and addr[0]!=0 faults.
  - Load with addr[1:0]!=0 faults.
  - A fault gives rsp_err=1, rsp_rdata=0, no write; latency unchanged.
- Undefined: addr[1:0] is ignored and never produces an error.

Test Plan:
- Reset then store addr=0x10, wdata=0xDEADBEEF, be=1111, WAIT_CYCLES=2 -> req_ready low for 4 cycles, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0. Load 0x10 -> rsp_rdata=0xDEADBEEF.
- Store 0x20 be=0101 wdata=0x11223344 over existing 0xAAAAAAAA -> load 0x20 returns 0xAA22AA44.
- Load addr=DEPTH*4 (0x400) -> rsp_err=1, rsp_rdata=0. Store to 0x400 then load word 0 -> word 0 unchanged.
- Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, new req_valid ignored. rsp_ready=1 -> IDLE next edge.
- Assert rst_n=0 in WAIT of store 0x30=0x12345678 (old 0x0) -> outputs reset immediately; later load 0x30 returns 0x0.
- With DMEM_ALIGN_CHECK_EN: load addr=0x13 -> rsp_err=1. Without the macro: same load returns word 0x10 contents with rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder side of the CPU data-memory port. Accepts one load/store at a
//   time over a valid/ready request channel, waits WAIT_CYCLES wait states,
//   performs the access on a word-organised RAM with byte-lane writes, and
//   returns read data plus an error flag over a valid/ready response channel.
//
// Parameters
//   DEPTH        number of 32-bit words (legal word index 0..DEPTH-1)
//   WAIT_CYCLES  wait states between acceptance and access (0..15)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    request present          req_ready  responder can accept
//   req_write    1 = store, 0 = load      req_addr   byte address
//   req_wdata    store data               req_be     store byte enables
//   rsp_valid    response present         rsp_ready  initiator takes response
//   rsp_rdata    load data (0 for stores and faults)
//   rsp_err      access faulted
//
// Optional feature
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned loads and misaligned
//                        word/halfword stores fault; otherwise addr[1:0] is
//                        ignored.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t         state;
   logic [3:0]     cnt;
   logic           lat_write;
   logic           lat_fault;
   logic [AW-1:0]  lat_idx;
   logic [31:0]    lat_wdata;
   logic [3:0]     lat_be;

   logic [31:0]    mem [DEPTH];

   // Faults are resolved at acceptance so only a single bit has to be carried
   // through the wait states instead of the whole address.
   logic range_fault;
   logic align_fault;

   assign range_fault = {2'b00, req_addr[31:2]} >= 32'(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
   always_comb begin
      align_fault = 1'b0;
      if (!req_write)
         align_fault = (req_addr[1:0] != 2'b00);
      else if (req_be == 4'b1111)
         align_fault = (req_addr[1:0] != 2'b00);
      else if (req_be == 4'b0011 || req_be == 4'b1100)
         align_fault = req_addr[0];
   end
`else
   logic unused_addr_lsbs;
   assign align_fault      = 1'b0;
   assign unused_addr_lsbs = ^req_addr[1:0];
`endif

   // The access happens on the edge that leaves WAIT with the counter at zero.
   logic access_now;
   logic mem_we;

   assign access_now = (state == WAIT) && (cnt == 4'd0);
   assign mem_we     = access_now && lat_write && !lat_fault;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
         lat_write <= 1'b0;
         lat_fault <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= 32'd0;
         lat_be    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  lat_write <= req_write;
                  lat_fault <= range_fault || align_fault;
                  lat_idx   <= req_addr[AW+1:2];
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  cnt       <= 4'(WAIT_CYCLES);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= lat_fault;
                  rsp_rdata <= (lat_fault || lat_write) ? 32'd0 : mem[lat_idx];
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the RAM array has no reset so it maps onto a memory macro; a reset
   // mid-WAIT cannot commit a write because state is forced to IDLE first.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i])
               mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed self-checking bench for dmem_responder (DEPTH=256, WAIT_CYCLES=2).
//   Inputs are driven on the falling edge, outputs sampled 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a request, scrambles req_* after acceptance, waits for the
   // response (bounded), returns it and completes the handshake.
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output logic er);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFFF;
      req_wdata = ~d; req_be = ~be;
      check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'd3);
      rd = rsp_rdata;
      er = rsp_err;
      check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("valid_clear_after_hs", {31'd0, rsp_valid}, 32'd0);
      check("ready_high_after_hs", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          n;

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
      req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;
      #12;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Store then load a full word.
      xact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er);
      check("st10_rdata", rd, 32'd0);
      check("st10_err", {31'd0, er}, 32'd0);
      xact(1'b0, 32'h10, 32'd0, 4'b0000, rd, er);
      check("ld10_rdata", rd, 32'hDEADBEEF);
      check("ld10_err", {31'd0, er}, 32'd0);

      // Byte-lane merge, then be=0000 leaves the word untouched.
      xact(1'b1, 32'h20, 32'hAAAAAAAA, 4'b1111, rd, er);
      xact(1'b1, 32'h20, 32'h11223344, 4'b0101, rd, er);
      xact(1'b0, 32'h20, 32'd0, 4'b1111, rd, er);
      check("ld20_lanes", rd, 32'hAA22AA44);
      xact(1'b1, 32'h20, 32'h55555555, 4'b0000, rd, er);
      check("st20_be0_err", {31'd0, er}, 32'd0);
      xact(1'b0, 32'h20, 32'd0, 4'b0000, rd, er);
      check("ld20_after_be0", rd, 32'hAA22AA44);

      // Out-of-range accesses fault and never write.
      xact(1'b1, 32'h0, 32'h0BADF00D, 4'b1111, rd, er);
      xact(1'b0, 32'h400, 32'd0, 4'b0000, rd, er);
      check("ld400_err", {31'd0, er}, 32'd1);
      check("ld400_rdata", rd, 32'd0);
      xact(1'b1, 32'h400, 32'hCAFEBABE, 4'b1111, rd, er);
      check("st400_err", {31'd0, er}, 32'd1);
      xact(1'b0, 32'h3FC, 32'd0, 4'b0000, rd, er);
      check("ld3fc_err", {31'd0, er}, 32'd0);
      xact(1'b0, 32'h0, 32'd0, 4'b0000, rd, er);
      check("ld0_unchanged", rd, 32'h0BADF00D);

      // Response held with rsp_ready low; competing request is ignored.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'b0000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("hold_latency", 32'(n), 32'd3);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
      req_wdata = 32'h99999999; req_be = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_rdata", rsp_rdata, 32'hDEADBEEF);
         check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
      check("hold_release_rdata", rsp_rdata, 32'd0);
      check("hold_release_ready", {31'd0, req_ready}, 32'd1);
      xact(1'b0, 32'h10, 32'd0, 4'b0000, rd, er);
      check("ignored_store_no_effect", rd, 32'hDEADBEEF);

      // Reset in WAIT aborts the store.
      xact(1'b1, 32'h30, 32'h0, 4'b1111, rd, er);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
      req_wdata = 32'h12345678; req_be = 4'b1111;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      xact(1'b0, 32'h30, 32'd0, 4'b0000, rd, er);
      check("ld30_after_abort", rd, 32'h0);

      // Reset in RESP drops the response.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'b0000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("resp_rst_latency", 32'(n), 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_resp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Misaligned load.
      xact(1'b0, 32'h13, 32'd0, 4'b0000, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
      check("ld13_err", {31'd0, er}, 32'd1);
      check("ld13_rdata", rd, 32'd0);
`else
      check("ld13_err", {31'd0, er}, 32'd0);
      check("ld13_rdata", rd, 32'hDEADBEEF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
